// File: rtl/bsg_fifo_rolly_replay_reader.sv
// Read-side replay controller for the rolly FIFO: sends entries with sequence numbers and keeps them until acked.
// Optional automatic replay on ack silence: define BSG_ROLLY_REPLAY_TIMEOUT_EN (uses timeout_p).
module bsg_fifo_rolly_replay_reader
  #(parameter int width_p           = 32
   ,parameter int max_outstanding_p = 8
   ,parameter int seq_width_p       = 8
   ,parameter int timeout_p         = 256)
   (input  logic                                     clk_i
   ,input  logic                                     reset_n_i
   ,input  logic [width_p-1:0]                       fifo_data_i
   ,input  logic                                     fifo_v_i
   ,output logic                                     fifo_yumi_o
   ,output logic                                     fifo_r_incr_o
   ,output logic                                     fifo_r_rewind_o
   ,output logic                                     fifo_r_forward_o
   ,output logic [width_p-1:0]                       link_data_o
   ,output logic [seq_width_p-1:0]                   link_seq_o
   ,output logic                                     link_v_o
   ,input  logic                                     link_ready_i
   ,input  logic                                     ack_v_i
   ,input  logic                                     ack_all_v_i
   ,input  logic                                     nack_v_i
   ,output logic [$clog2(max_outstanding_p+1)-1:0]   outstanding_o
   ,output logic [15:0]                              replay_cnt_o
   );

   localparam int out_w_lp = $clog2(max_outstanding_p+1);
   localparam bit params_ok_lp = (max_outstanding_p >= 1) && (seq_width_p < 31)
                                 && ((2**seq_width_p) > max_outstanding_p) && (timeout_p >= 2);

   typedef enum logic {eRun, eRewind} state_e;

   state_e                 state_r;
   logic [seq_width_p-1:0] send_seq_r, ack_seq_r, ack_seq_n;
   logic [out_w_lp-1:0]    outstanding_r;
   logic [15:0]            replay_cnt_r;
   logic run, ack_all, ack, rw, timeout_fire, full, block, link_v, yumi;

   // NOTE: every strobe is qualified by reset_n_i so it drops the instant reset asserts, not at the next edge.
   assign run       = reset_n_i & (state_r == eRun);
   assign ack_all   = run & ack_all_v_i;
   assign ack       = run & ack_v_i & ~ack_all_v_i & (outstanding_r != '0);
   assign rw        = run & ~ack_all_v_i & (nack_v_i | timeout_fire);
   assign full      = (outstanding_r == out_w_lp'(max_outstanding_p));
   assign block     = rw | ack_all | full;
   assign link_v    = run & fifo_v_i & ~block;
   assign yumi      = link_v & link_ready_i;
   // A same-cycle ack is retired before a rewind, so replay starts just past it.
   assign ack_seq_n = ack_seq_r + seq_width_p'(ack);

`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
   localparam int to_w_lp = (timeout_p > 1) ? $clog2(timeout_p) : 1;
   logic [to_w_lp-1:0] timer_r;

   assign timeout_fire = (state_r == eRun) & (timer_r == to_w_lp'(timeout_p-1));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         timer_r <= '0;
      else if (ack_v_i | ack_all_v_i | rw | timeout_fire | (state_r == eRewind) | (outstanding_r == '0))
         timer_r <= '0;
      else
         timer_r <= timer_r + to_w_lp'(1);
   end
`else
   assign timeout_fire = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, and every flop clears asynchronously.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r       <= eRun;
         send_seq_r    <= '0;
         ack_seq_r     <= '0;
         outstanding_r <= '0;
         replay_cnt_r  <= '0;
      end else begin
         state_r   <= rw ? eRewind : eRun;
         ack_seq_r <= ack_all ? send_seq_r : ack_seq_n;
         if (rw) begin
            send_seq_r    <= ack_seq_n;
            outstanding_r <= '0;
            if (replay_cnt_r != 16'hFFFF)
               replay_cnt_r <= replay_cnt_r + 16'd1;
         end else if (ack_all) begin
            outstanding_r <= '0;
         end else begin
            if (yumi)
               send_seq_r <= send_seq_r + seq_width_p'(1);
            outstanding_r <= outstanding_r + out_w_lp'(yumi) - out_w_lp'(ack);
         end
      end
   end

   assign fifo_yumi_o      = yumi;
   assign fifo_r_incr_o    = ack;
   assign fifo_r_forward_o = ack_all;
   assign fifo_r_rewind_o  = (state_r == eRewind);
   assign link_v_o         = link_v;
   assign link_data_o      = reset_n_i ? fifo_data_i : '0;
   assign link_seq_o       = send_seq_r;
   assign outstanding_o    = outstanding_r;
   assign replay_cnt_o     = replay_cnt_r;

   // The rewind cycle is a bubble; the far end must stay quiet during it.
   assert property (@(posedge clk_i) disable iff (!reset_n_i)
                    (state_r == eRewind) |-> !(ack_v_i | ack_all_v_i | nack_v_i));
   assert property (@(posedge clk_i) disable iff (!reset_n_i)
                    fifo_r_forward_o |-> !(fifo_r_rewind_o | fifo_r_incr_o));
   assert property (@(posedge clk_i) params_ok_lp);

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_reader.sv
// Self-checking bench for bsg_fifo_rolly_replay_reader: small rolly-FIFO model, link scoreboard,
// a combinational vector table and hand-written multi-cycle sequences.
module tb_bsg_fifo_rolly_replay_reader;
   localparam int width_lp   = 8;
   localparam int max_out_lp = 8;
   localparam int seq_w_lp   = 8;
`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
   localparam int timeout_lp = 16;
`else
   localparam int timeout_lp = 256;
`endif
   localparam int out_w_lp = $clog2(max_out_lp+1);

   logic clk_i = 1'b0;
   logic reset_n_i = 1'b0;
   logic [width_lp-1:0] fifo_data_i, link_data_o;
   logic fifo_v_i, fifo_yumi_o, fifo_r_incr_o, fifo_r_rewind_o, fifo_r_forward_o;
   logic [seq_w_lp-1:0] link_seq_o;
   logic link_v_o;
   logic link_ready_i = 1'b0, ack_v_i = 1'b0, ack_all_v_i = 1'b0, nack_v_i = 1'b0;
   logic [out_w_lp-1:0] outstanding_o;
   logic [15:0] replay_cnt_o;

   always #5 clk_i = ~clk_i;

   bsg_fifo_rolly_replay_reader #(.width_p(width_lp), .max_outstanding_p(max_out_lp),
                                  .seq_width_p(seq_w_lp), .timeout_p(timeout_lp)) dut
     (.clk_i(clk_i), .reset_n_i(reset_n_i), .fifo_data_i(fifo_data_i), .fifo_v_i(fifo_v_i),
      .fifo_yumi_o(fifo_yumi_o), .fifo_r_incr_o(fifo_r_incr_o), .fifo_r_rewind_o(fifo_r_rewind_o),
      .fifo_r_forward_o(fifo_r_forward_o), .link_data_o(link_data_o), .link_seq_o(link_seq_o),
      .link_v_o(link_v_o), .link_ready_i(link_ready_i), .ack_v_i(ack_v_i), .ack_all_v_i(ack_all_v_i),
      .nack_v_i(nack_v_i), .outstanding_o(outstanding_o), .replay_cnt_o(replay_cnt_o));

   // Rolly FIFO read-side model: rptr for reads, cptr as the replay checkpoint.
   logic [width_lp-1:0] mem [16];
   logic [3:0] wptr = 4'd0, rptr, cptr;
   logic tbl_mode = 1'b0, tbl_fifo_v = 1'b0;
   assign fifo_v_i    = tbl_mode ? tbl_fifo_v : (rptr != wptr);
   assign fifo_data_i = mem[rptr];

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rptr <= 4'd0;
         cptr <= 4'd0;
      end else if (fifo_r_rewind_o) begin
         rptr <= cptr + 4'(fifo_r_incr_o);
         cptr <= cptr + 4'(fifo_r_incr_o);
      end else begin
         if (fifo_yumi_o) rptr <= rptr + 4'd1;
         if (fifo_r_forward_o) cptr <= rptr;
         else if (fifo_r_incr_o) cptr <= cptr + 4'd1;
      end
   end

   typedef struct packed { logic [seq_w_lp-1:0] seq; logic [width_lp-1:0] data; } xfer_t;
   xfer_t exp_q[$];

   // in = {fifo_v, link_ready, ack, ack_all, nack}; ex = {link_v, yumi, r_incr, r_forward}
   typedef struct { int out_pre; logic [4:0] in; logic [3:0] ex; } vec_t;
   vec_t tbl [13];

   int checks = 0, errors = 0;
   int yumi_cnt = 0, incr_cnt = 0, fwd_cnt = 0, peak_out = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_fifo(input logic [width_lp-1:0] d);
      mem[wptr] = d;
      wptr = wptr + 4'd1;
   endtask

   task automatic expect_x(input logic [seq_w_lp-1:0] s, input logic [width_lp-1:0] d);
      exp_q.push_back({s, d});
   endtask

   task automatic do_reset();
      {link_ready_i, ack_v_i, ack_all_v_i, nack_v_i, tbl_mode} = '0;
      #2 reset_n_i = 1'b0;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      wptr = 4'd0;
      repeat (2) @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      yumi_cnt = 0; incr_cnt = 0; fwd_cnt = 0; peak_out = 0;
   endtask

   task automatic run_rows(input int phase);
      for (int i = 0; i < 13; i++) begin
         if (tbl[i].out_pre == phase) begin
            tick();
            check($sformatf("vec%0d_out", i), 32'(outstanding_o), 32'(phase));
            tbl_mode = 1'b1;
            {tbl_fifo_v, link_ready_i, ack_v_i, ack_all_v_i, nack_v_i} = tbl[i].in;
            #1;
            check($sformatf("vec%0d_strobes", i),
                  32'({link_v_o, fifo_yumi_o, fifo_r_incr_o, fifo_r_forward_o}), 32'(tbl[i].ex));
            {tbl_mode, link_ready_i, ack_v_i, ack_all_v_i, nack_v_i} = '0;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] sh;
      int k;
      tbl = '{'{0, 5'b11000, 4'b1100}, '{0, 5'b10000, 4'b1000}, '{0, 5'b01000, 4'b0000},
              '{0, 5'b11100, 4'b1100}, '{0, 5'b11001, 4'b0000}, '{0, 5'b11010, 4'b0001},
              '{0, 5'b11011, 4'b0001}, '{2, 5'b11100, 4'b1110}, '{2, 5'b11110, 4'b0001},
              '{2, 5'b11101, 4'b0010}, '{2, 5'b10100, 4'b1010}, '{8, 5'b11000, 4'b0000},
              '{8, 5'b11100, 4'b0010}};

      // Link scoreboard and strobe counters, sampled on the falling edge.
      fork
         forever begin
            @(negedge clk_i);
            if (reset_n_i) begin
               if (fifo_r_incr_o) incr_cnt++;
               if (fifo_r_forward_o) fwd_cnt++;
               if (int'(outstanding_o) > peak_out) peak_out = int'(outstanding_o);
               if (fifo_yumi_o) begin
                  yumi_cnt++;
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL sb_extra_send: seq %0h data %0h, expected no send", link_seq_o, link_data_o);
                  end else begin
                     xfer_t e;
                     e = exp_q.pop_front();
                     check("sb_seq", 32'(link_seq_o), 32'(e.seq));
                     check("sb_data", 32'(link_data_o), 32'(e.data));
                  end
               end
            end
         end
      join_none

      // Reset state
      do_reset();
      #1;
      check("rst_out", 32'(outstanding_o), 32'd0);
      check("rst_replay", 32'(replay_cnt_o), 32'd0);
      check("rst_seq", 32'(link_seq_o), 32'd0);
      check("rst_strobes", 32'({link_v_o, fifo_yumi_o, fifo_r_rewind_o, fifo_r_incr_o, fifo_r_forward_o}), 32'd0);

      // Combinational vectors at outstanding 0, 2 and 8
      run_rows(0);
      for (int i = 0; i < 8; i++) begin
         push_fifo(8'h10 + 8'(i));
         expect_x(8'(i), 8'h10 + 8'(i));
      end
      link_ready_i = 1'b1;
      repeat (2) tick();
      link_ready_i = 1'b0;
      run_rows(2);
      link_ready_i = 1'b1;
      repeat (6) tick();
      link_ready_i = 1'b0;
      run_rows(8);
      do_reset();

      // Ordered acks two cycles after each send
      for (int i = 0; i < 4; i++) begin
         push_fifo(8'hC0 + 8'(i));
         expect_x(8'(i), 8'hC0 + 8'(i));
      end
      sh = 2'b00;
      link_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ack_v_i = sh[1];
         #1 sh = {sh[0], fifo_yumi_o};
         tick();
      end
      {ack_v_i, link_ready_i} = '0;
      check("stream_incr_cnt", 32'(incr_cnt), 32'd4);
      check("stream_peak_out", 32'(peak_out), 32'd2);
      check("stream_out_end", 32'(outstanding_o), 32'd0);
      do_reset();

      // Window limit: ten entries, only eight go out until an ack arrives
      for (int i = 0; i < 10; i++) begin
         push_fifo(8'h30 + 8'(i));
         if (i < 9) expect_x(8'(i), 8'h30 + 8'(i));
      end
      link_ready_i = 1'b1;
      repeat (12) tick();
      check("win_yumis", 32'(yumi_cnt), 32'd8);
      check("win_blocked", 32'({fifo_v_i, link_v_o}), 32'b10);
      check("win_out", 32'(outstanding_o), 32'd8);
      ack_v_i = 1'b1;
      #1 check("win_ack_cycle", 32'({link_v_o, fifo_r_incr_o}), 32'b01);
      tick();
      ack_v_i = 1'b0;
      #1 check("win_resume", 32'({link_v_o, link_seq_o}), {23'd0, 1'b1, 8'd8});
      tick();
      link_ready_i = 1'b0;
      check("win_yumis_after", 32'(yumi_cnt), 32'd9);
      do_reset();

      // Nack replay after two acks
      for (int i = 0; i < 6; i++) push_fifo(8'hA0 + 8'(i));
      for (int i = 0; i < 5; i++) expect_x(8'(i), 8'hA0 + 8'(i));
      link_ready_i = 1'b1;
      repeat (5) tick();
      link_ready_i = 1'b0;
      check("nack_out_sent", 32'(outstanding_o), 32'd5);
      ack_v_i = 1'b1;
      repeat (2) tick();
      ack_v_i = 1'b0;
      check("nack_incr_cnt", 32'(incr_cnt), 32'd2);
      check("nack_out_acked", 32'(outstanding_o), 32'd3);
      nack_v_i = 1'b1;
      link_ready_i = 1'b1;
      for (int i = 2; i < 6; i++) expect_x(8'(i), 8'hA0 + 8'(i));
      #1 check("nack_trig", 32'({link_v_o, fifo_yumi_o, fifo_r_rewind_o}), 32'd0);
      tick();
      nack_v_i = 1'b0;
      #1 check("nack_bubble", 32'({fifo_r_rewind_o, link_v_o, fifo_yumi_o}), 32'b100);
      tick();
      check("nack_resend", 32'({fifo_r_rewind_o, link_v_o, link_seq_o, link_data_o}),
            {14'd0, 1'b0, 1'b1, 8'd2, 8'hA2});
      check("nack_replay_cnt", 32'(replay_cnt_o), 32'd1);
      repeat (4) tick();
      link_ready_i = 1'b0;
      check("nack_out_resent", 32'(outstanding_o), 32'd4);
      ack_all_v_i = 1'b1;
      #1 check("nack_fwd", 32'({fifo_r_forward_o, fifo_r_incr_o}), 32'b10);
      tick();
      ack_all_v_i = 1'b0;
      check("nack_fwd_done", 32'({outstanding_o, link_seq_o}), {20'd0, 4'd0, 8'd6});
      do_reset();

      // Simultaneous ack and nack, then ack_all together with ack
      for (int i = 0; i < 4; i++) push_fifo(8'h50 + 8'(i));
      for (int i = 0; i < 3; i++) expect_x(8'(i), 8'h50 + 8'(i));
      link_ready_i = 1'b1;
      repeat (3) tick();
      link_ready_i = 1'b0;
      check("an_out", 32'(outstanding_o), 32'd3);
      {ack_v_i, nack_v_i} = 2'b11;
      for (int i = 1; i < 4; i++) expect_x(8'(i), 8'h50 + 8'(i));
      #1 check("an_trig", 32'({fifo_r_incr_o, link_v_o, fifo_r_forward_o}), 32'b100);
      tick();
      {ack_v_i, nack_v_i} = 2'b00;
      #1 check("an_rewind", 32'({fifo_r_rewind_o, outstanding_o}), {27'd0, 1'b1, 4'd0});
      link_ready_i = 1'b1;
      tick();
      check("an_resend", 32'({link_seq_o, link_data_o}), {16'd0, 8'd1, 8'h51});
      repeat (3) tick();
      link_ready_i = 1'b0;
      check("an_out_resent", 32'(outstanding_o), 32'd3);
      {ack_v_i, ack_all_v_i} = 2'b11;
      #1 check("aa_fwd_only", 32'({fifo_r_forward_o, fifo_r_incr_o}), 32'b10);
      tick();
      {ack_v_i, ack_all_v_i} = 2'b00;
      #1 check("aa_done", 32'({outstanding_o, fifo_r_rewind_o}), 32'd0);
      do_reset();

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 4; i++) push_fifo(8'h60 + 8'(i));
      for (int i = 0; i < 3; i++) expect_x(8'(i), 8'h60 + 8'(i));
      link_ready_i = 1'b1;
      repeat (3) tick();
      link_ready_i = 1'b0;
      check("mid_out", 32'(outstanding_o), 32'd3);
      link_ready_i = 1'b1;
      #1 reset_n_i = 1'b0;
      #1 check("mid_rst_outputs",
               32'({link_v_o, fifo_yumi_o, fifo_r_incr_o, fifo_r_forward_o, fifo_r_rewind_o,
                    outstanding_o, link_seq_o, link_data_o}), 32'd0);
      check("mid_rst_replay", 32'(replay_cnt_o), 32'd0);
      link_ready_i = 1'b0;
      wptr = 4'd0;
      check("mid_sb_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      #1 check("mid_release", 32'({link_seq_o, outstanding_o}), 32'd0);

`ifdef BSG_ROLLY_REPLAY_TIMEOUT_EN
      // Timeout: the trigger fires 16 cycles after the send, the rewind pulse shows one cycle later.
      do_reset();
      push_fifo(8'h77);
      expect_x(8'd0, 8'h77);
      link_ready_i = 1'b1;
      #1 check("to_first_send", 32'(fifo_yumi_o), 32'd1);
      for (int r = 1; r <= 2; r++) begin
         k = 0;
         while (k < 40) begin
            tick();
            k++;
            if (fifo_r_rewind_o) break;
         end
         check($sformatf("to_delay_%0d", r), 32'(k), 32'd17);
         check($sformatf("to_replay_cnt_%0d", r), 32'(replay_cnt_o), 32'(r));
         expect_x(8'd0, 8'h77);
         tick();
         check($sformatf("to_resend_%0d", r), 32'({fifo_yumi_o, link_seq_o}), {23'd0, 1'b1, 8'd0});
      end
      tick();
      link_ready_i = 1'b0;
      ack_all_v_i = 1'b1;
      tick();
      ack_all_v_i = 1'b0;
`endif

      do_reset();
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
